// File: rtl/proc_dmem_ctrl_pkg.sv
// Shared types and constants for the processor data-memory stage.
// The trace path is built only when PROC_DMEM_TRACE_EN is defined.
package proc_dmem_package;

    localparam int PROC_DMEM_ADDR_W      = 8;
    localparam int PROC_DMEM_DATA_W      = 8;
    localparam int PROC_DMEM_TRACE_DEPTH = 4;

    // One committed write as seen by the sign-off harness.
    typedef struct packed {
        logic [PROC_DMEM_ADDR_W-1:0] addr;
        logic [PROC_DMEM_DATA_W-1:0] data;
    } proc_dmem_trace_t;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } proc_dmem_trace_state_t;

    // Drop counter step that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] proc_dmem_sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/proc_dmem_ctrl_trace_fifo.sv
// Trace FIFO for committed writes: storage, occupancy FSM and drop counter.
// Pushes never stall the core; a push into a full FIFO without a pop is dropped.
// Instantiated by proc_dmem_ctrl only when PROC_DMEM_TRACE_EN is defined.
module proc_dmem_trace_fifo
    import proc_dmem_package::*;
#(
    parameter int ADDR_W = PROC_DMEM_ADDR_W,
    parameter int DATA_W = PROC_DMEM_DATA_W,
    parameter int DEPTH  = PROC_DMEM_TRACE_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              trace_ready,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [7:0]        trace_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]      addr_mem_r [DEPTH];
    logic [DATA_W-1:0]      data_mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic [7:0]             drops_r;
    proc_dmem_trace_state_t state_r;
    proc_dmem_trace_state_t state_next_s;

    logic pop_s;
    logic accept_s;
    logic drop_s;

    // Pop depends only on registered state plus ready; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop_s    = (state_r == ACTIVE) && trace_ready;
        accept_s = push_valid && ((count_r < CNT_W'(DEPTH)) || pop_s);
        drop_s   = push_valid && !accept_s;
    end

    // Next occupancy and FSM state.
    always_comb begin
        count_next_s = count_r;
        state_next_s = state_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ACTIVE: begin
                if (pop_s && !accept_s && (count_r == CNT_W'(1))) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Control registers: state, pointers, occupancy and saturating drop count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= EMPTY;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            drops_r  <= 8'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s) begin
                drops_r <= proc_dmem_sat_inc(drops_r);
            end
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= '0;
                data_mem_r[i] <= '0;
            end
        end else if (accept_s) begin
            addr_mem_r[wr_ptr_r] <= push_addr;
            data_mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign trace_valid = (state_r == ACTIVE);
    assign trace_addr  = addr_mem_r[rd_ptr_r];
    assign trace_data  = data_mem_r[rd_ptr_r];
    assign trace_drops = drops_r;

endmodule

// File: rtl/proc_dmem_ctrl.sv
// Data-memory stage: 2^ADDR_W x DATA_W array, combinational read, clocked write.
// Define PROC_DMEM_TRACE_EN to add the committed-write trace FIFO; otherwise
// the trace outputs are tied to zero and trace_ready is ignored.
module proc_dmem_ctrl
    import proc_dmem_package::*;
#(
    parameter int ADDR_W      = PROC_DMEM_ADDR_W,
    parameter int DATA_W      = PROC_DMEM_DATA_W,
    parameter int TRACE_DEPTH = PROC_DMEM_TRACE_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dataaddr_sig,
    input  logic [DATA_W-1:0] dataout_sig,
    input  logic              wen_sig,
    output logic [DATA_W-1:0] datain_sig,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [7:0]        trace_drops
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    // Array write; reset clears every byte so reads return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wen_sig) begin
            mem_r[dataaddr_sig] <= dataout_sig;
        end
    end

    // Read shows the pre-write value during a same-address write.
    assign datain_sig = mem_r[dataaddr_sig];

`ifdef PROC_DMEM_TRACE_EN
    proc_dmem_trace_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (wen_sig),
        .push_addr   (dataaddr_sig),
        .push_data   (dataout_sig),
        .trace_ready (trace_ready),
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_drops (trace_drops)
    );
`else
    logic unused_trace_ready_s;

    assign unused_trace_ready_s = trace_ready;
    assign trace_valid          = 1'b0;
    assign trace_addr           = '0;
    assign trace_data           = '0;
    assign trace_drops          = 8'd0;
`endif

endmodule

// File: tb/tb_proc_dmem_ctrl.sv
// Self-checking bench for proc_dmem_ctrl with a reference array model and a
// scoreboard queue of expected trace entries. Trace expectations follow
// PROC_DMEM_TRACE_EN: with it undefined every trace output must stay zero.
module tb_proc_dmem_ctrl;
    import proc_dmem_package::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataaddr_sig;
    logic [7:0] dataout_sig;
    logic       wen_sig;
    logic [7:0] datain_sig;
    logic       trace_valid;
    logic       trace_ready;
    logic [7:0] trace_addr;
    logic [7:0] trace_data;
    logic [7:0] trace_drops;

    int n_checks = 0;
    int n_errors = 0;

    proc_dmem_trace_t exp_q[$];
    logic [7:0]       mdl_mem [256];
    int               mdl_drops;

    proc_dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .dataaddr_sig (dataaddr_sig),
        .dataout_sig  (dataout_sig),
        .wen_sig      (wen_sig),
        .datain_sig   (datain_sig),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .trace_drops  (trace_drops)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        exp_q.delete();
        mdl_drops = 0;
    endtask

    // Drive one cycle (called just after a rising edge), check at the falling edge, update model.
    task automatic cycle(input logic w, input logic [7:0] a, input logic [7:0] d, input logic r);
        int occ;
        bit pop;
        proc_dmem_trace_t ent;
        wen_sig      = w;
        dataaddr_sig = a;
        dataout_sig  = d;
        trace_ready  = r;
        @(negedge clk);
        check_eq("datain", {24'd0, datain_sig}, {24'd0, mdl_mem[a]});
`ifdef PROC_DMEM_TRACE_EN
        occ = exp_q.size();
        pop = (occ != 0) && r;
        check_eq("trace_valid", {31'd0, trace_valid}, (occ != 0) ? 32'd1 : 32'd0);
        if (occ != 0) begin
            check_eq("trace_addr", {24'd0, trace_addr}, {24'd0, exp_q[0].addr});
            check_eq("trace_data", {24'd0, trace_data}, {24'd0, exp_q[0].data});
        end
        check_eq("trace_drops", {24'd0, trace_drops}, mdl_drops);
        if (pop) void'(exp_q.pop_front());
        if (w) begin
            if ((occ < 4) || pop) begin
                ent.addr = a;
                ent.data = d;
                exp_q.push_back(ent);
            end else if (mdl_drops < 255) begin
                mdl_drops++;
            end
        end
`else
        check_eq("trace_valid_off", {31'd0, trace_valid}, 32'd0);
        check_eq("trace_addr_off", {24'd0, trace_addr}, 32'd0);
        check_eq("trace_data_off", {24'd0, trace_data}, 32'd0);
        check_eq("trace_drops_off", {24'd0, trace_drops}, 32'd0);
`endif
        if (w) mdl_mem[a] = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        wen_sig      = 1'b0;
        dataaddr_sig = 8'h00;
        dataout_sig  = 8'h00;
        trace_ready  = 1'b0;
        mdl_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_datain_00", {24'd0, datain_sig}, 32'd0);
        dataaddr_sig = 8'hFF;
        #1;
        check_eq("rst_datain_ff", {24'd0, datain_sig}, 32'd0);
        check_eq("rst_valid", {31'd0, trace_valid}, 32'd0);
        check_eq("rst_taddr", {24'd0, trace_addr}, 32'd0);
        check_eq("rst_tdata", {24'd0, trace_data}, 32'd0);
        check_eq("rst_drops", {24'd0, trace_drops}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 8'hFF, 8'h00, 1'b0);

        // Single write with consumer ready: old value same cycle, new value and trace next cycle
        cycle(1'b1, 8'h3C, 8'hA5, 1'b1);
        cycle(1'b0, 8'h3C, 8'h00, 1'b1);
        cycle(1'b0, 8'h3C, 8'h00, 1'b1);

        // Five writes into a stalled consumer: one drop, then an in-order drain
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 8'(8'h01 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'(8'h10 + i), 8'h00, 1'b1);

        // Full FIFO with a write and a pop in the same cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 8'(8'h30 + i), 1'b0);
        cycle(1'b1, 8'h24, 8'h34, 1'b1);
        cycle(1'b1, 8'h25, 8'h35, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'(8'h20 + i), 8'h00, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 262; i++) cycle(1'b1, 8'(i), 8'(i ^ 8'h5A), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'(i), 8'h00, 1'b1);

        // Random traffic on a small address window to hit read-during-write
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 15)),
                  8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset mid-drain with three entries pending
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 8'h41, 8'h00, 1'b1);
        dataaddr_sig = 8'h42;
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, trace_valid}, 32'd0);
        check_eq("midrst_datain", {24'd0, datain_sig}, 32'd0);
        check_eq("midrst_drops", {24'd0, trace_drops}, 32'd0);
        check_eq("midrst_taddr", {24'd0, trace_addr}, 32'd0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 8'h43, 8'h00, 1'b1);
        cycle(1'b1, 8'h50, 8'h77, 1'b0);
        cycle(1'b0, 8'h50, 8'h00, 1'b1);
        cycle(1'b0, 8'h50, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_dmem_ctrl.md
# proc_dmem_ctrl

Data-memory stage directly downstream of the processor core: consumes `dataaddr_sig`, `dataout_sig` and `wen_sig`, and produces `datain_sig`. The block holds a 256×8 byte array with combinational read and clocked write. It also captures every committed write into a small trace FIFO, drained over a valid/ready port for the equivalence and sign-off harness. Trace overflow never stalls the core; dropped entries are counted.

## Interface
- `ADDR_W`, default 8, address width; the array has 2^ADDR_W entries.
- `DATA_W`, default 8, data width.
- `TRACE_DEPTH`, default 4, trace FIFO entries; must be a power of two and ≥2.
- `clk  in  1  clock, rising edge`
- `rst  in  1  reset, asynchronous, active-low`
- `dataaddr_sig  in  ADDR_W  core data address`
- `dataout_sig  in  DATA_W  core write data`
- `wen_sig  in  1  core write enable`
- `datain_sig  out  DATA_W  read data, mem[dataaddr_sig]`
- `trace_valid  out  1  trace head entry valid`
- `trace_ready  in  1  trace consumer ready`
- `trace_addr  out  ADDR_W  head entry address`
- `trace_data  out  DATA_W  head entry data`
- `trace_drops  out  8  saturating count of dropped trace entries`

## Operation
- Array:
  - Write `mem[dataaddr_sig] <= dataout_sig` on a rising edge with `wen_sig=1`.
  - `datain_sig` is a purely combinational read of the array.
- Read during write to the same address: `datain_sig` shows the old value in that cycle and the new value from the next cycle.
- Trace push: each cycle with `wen_sig=1` pushes `{dataaddr_sig, dataout_sig}`.
- Trace pop: occurs when `trace_valid && trace_ready`.
- Push acceptance:
  - Accepted if `count < TRACE_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped, `trace_drops` increments (saturates at 255), and the array write still occurs.
- Simultaneous push and pop: `count` is unchanged and the new entry goes to the tail.
- Pointers: read/write pointers are log2(TRACE_DEPTH) bits and wrap naturally. `count` is log2(TRACE_DEPTH)+1 bits.
- Trace FSM, two states:
  - EMPTY (`count=0`): goes to ACTIVE on push.
  - ACTIVE: goes to EMPTY when a pop with no push occurs at `count=1`.
  - `trace_valid = (state==ACTIVE)`.
- Handshake:
  - `trace_addr`/`trace_data` stay stable while `trace_valid && !trace_ready`.
  - Once asserted, `trace_valid` does not deassert without a pop.

## Timing
- Reset asserted (`rst=0`), asynchronous:
  - All array bytes = 0, so `datain_sig` = 0.
  - FIFO empty, `trace_valid=0`, `trace_drops=0`.
  - `trace_addr`/`trace_data` = 0.
- Reset asserted mid-operation: pending trace entries and the drop count are discarded immediately.
- Deassertion is sampled at the next rising edge; the first write can commit on that edge.
- Write-to-read latency: 1 cycle.
- Write-to-`trace_valid` latency: 1 cycle when the FIFO was empty.
- Trace throughput: 1 entry per cycle.
- No combinational path from `trace_ready` to any output.

## Configuration
- `PROC_DMEM_TRACE_EN` defined:
  - Trace FIFO, FSM and drop counter are instantiated as described.
- `PROC_DMEM_TRACE_EN` not defined:
  - No FIFO logic; `trace_valid`, `trace_addr`, `trace_data` and `trace_drops` are tied to 0.
  - `trace_ready` is ignored.
  - Array behaviour is identical.

## Structure
- Package `proc_dmem_package` holds:
  - `proc_dmem_trace_t` struct `{addr, data}`.
  - Constants `PROC_DMEM_ADDR_W=8`, `PROC_DMEM_DATA_W=8`, `PROC_DMEM_TRACE_DEPTH=4`.
  - Trace FSM state enum `proc_dmem_trace_state_t {EMPTY, ACTIVE}`.
- One sub-module, `proc_dmem_trace_fifo`: FIFO, FSM and drop counter, instantiated under the macro.
- The array and read mux stay in `proc_dmem_ctrl`.

## Test plan
- Reset then idle: all outputs read 0; reading addresses 0x00 and 0xFF gives `datain_sig=0`.
- Write 0xA5 to 0x3C with `trace_ready=1`:
  - Same cycle: `datain_sig` at 0x3C = 0.
  - Next cycle: `datain_sig` = 0xA5, and `trace_valid=1` with `{0x3C, 0xA5}` for one cycle.
- Five back-to-back writes (0x01..0x05 to 0x10..0x14) with `trace_ready=0`:
  - The FIFO holds the first four; `trace_drops=1`.
  - Raising `trace_ready` pops addresses 0x10..0x13 in order; `trace_valid` falls after 4 cycles.
- Full FIFO, write plus `trace_ready=1` in the same cycle: push is accepted, `trace_drops` is unchanged, `count` stays 4.
- Assert `rst` low mid-drain with 3 entries pending: `trace_valid` and `datain_sig` go to 0 immediately; after release the FIFO is empty.
- Build without `PROC_DMEM_TRACE_EN`: array behaviour matches the earlier scenarios; trace outputs are constant 0.
